// File: rtl/mr_wb_arb.sv
// Two-requester Wishbone pipelined arbiter: m0 (load/store) and m1 (fetch) share one slave bus.
// Round-robin on ties, no preemption, and a watchdog that aborts a bus cycle the slave never answers.
module mr_wb_arb #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned AW      = 30,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_cyc_i,
   input  logic              m0_stb_i,
   input  logic              m0_we_i,
   input  logic [AW-1:0]     m0_addr_i,
   input  logic [XLEN/8-1:0] m0_sel_i,
   input  logic [XLEN-1:0]   m0_dat_i,
   output logic              m0_ack_o,
   output logic              m0_err_o,
   output logic              m0_stall_o,
   output logic [XLEN-1:0]   m0_dat_o,
   input  logic              m1_cyc_i,
   input  logic              m1_stb_i,
   input  logic              m1_we_i,
   input  logic [AW-1:0]     m1_addr_i,
   input  logic [XLEN/8-1:0] m1_sel_i,
   input  logic [XLEN-1:0]   m1_dat_i,
   output logic              m1_ack_o,
   output logic              m1_err_o,
   output logic              m1_stall_o,
   output logic [XLEN-1:0]   m1_dat_o,
   output logic              s_cyc_o,
   output logic              s_stb_o,
   output logic              s_we_o,
   output logic [AW-1:0]     s_addr_o,
   output logic [XLEN/8-1:0] s_sel_o,
   output logic [XLEN-1:0]   s_dat_o,
   input  logic              s_ack_i,
   input  logic              s_err_i,
   input  logic              s_stall_i,
   input  logic [XLEN-1:0]   s_dat_i,
   output logic [1:0]        grant_o
);

   localparam logic [15:0] WdogMax = 16'(TIMEOUT);

   typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

   state_e      state_q, state_d;
   logic        last_grant_q, last_grant_d;
   logic [15:0] wdog_q, wdog_d;

   logic own0, own1, own_cyc, oth_cyc, timeout;

   assign own0    = (state_q == StOwn0);
   assign own1    = (state_q == StOwn1);
   assign own_cyc = own1 ? m1_cyc_i : m0_cyc_i;
   assign oth_cyc = own1 ? m0_cyc_i : m1_cyc_i;
   assign timeout = (own0 | own1) && (wdog_q == WdogMax);

   assign grant_o  = {own1, own0};
   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;

   // Bus mux: driven only from the registered owner, never from live requests.
   always_comb begin
      s_cyc_o    = 1'b0;
      s_stb_o    = 1'b0;
      s_we_o     = 1'b0;
      s_addr_o   = '0;
      s_sel_o    = '0;
      s_dat_o    = '0;
      m0_ack_o   = 1'b0;
      m0_err_o   = 1'b0;
      m0_stall_o = m0_cyc_i;
      m1_ack_o   = 1'b0;
      m1_err_o   = 1'b0;
      m1_stall_o = m1_cyc_i;
      unique case (state_q)
         StOwn0: begin
            s_cyc_o    = m0_cyc_i & ~timeout;
            s_stb_o    = m0_stb_i & ~timeout;
            s_we_o     = m0_we_i;
            s_addr_o   = m0_addr_i;
            s_sel_o    = m0_sel_i;
            s_dat_o    = m0_dat_i;
            m0_ack_o   = s_ack_i;
            m0_err_o   = s_err_i | timeout;
            m0_stall_o = s_stall_i;
         end
         StOwn1: begin
            s_cyc_o    = m1_cyc_i & ~timeout;
            s_stb_o    = m1_stb_i & ~timeout;
            s_we_o     = m1_we_i;
            s_addr_o   = m1_addr_i;
            s_sel_o    = m1_sel_i;
            s_dat_o    = m1_dat_i;
            m1_ack_o   = s_ack_i;
            m1_err_o   = s_err_i | timeout;
            m1_stall_o = s_stall_i;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      wdog_d       = wdog_q;
      unique case (state_q)
         StIdle: begin
            wdog_d = '0;
            if (m0_cyc_i && m1_cyc_i) begin
               state_d = last_grant_q ? StOwn0 : StOwn1;
            end else if (m0_cyc_i) begin
               state_d = StOwn0;
            end else if (m1_cyc_i) begin
               state_d = StOwn1;
            end
         end
         StOwn0, StOwn1: begin
            if (s_ack_i || s_err_i) begin
               wdog_d = '0;
            end else if (s_cyc_o && (wdog_q != WdogMax)) begin
               wdog_d = wdog_q + 16'd1;
            end
            if (timeout) begin
               state_d      = StIdle;
               last_grant_d = own1;
            end else if (!own_cyc) begin
               state_d      = oth_cyc ? (own1 ? StOwn0 : StOwn1) : StIdle;
               last_grant_d = own1;
            end
         end
         default: state_d = StIdle;
      endcase
      // A new owner starts with a fresh watchdog budget.
      if (state_d != state_q) begin
         wdog_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         last_grant_q <= 1'b1;
         wdog_q       <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         wdog_q       <= wdog_d;
      end
   end

endmodule

// File: tb/tb_mr_wb_arb.sv
// Directed bench for mr_wb_arb (TIMEOUT=4): tie-break, handover, stalled read, round-robin,
// watchdog abort and mid-transaction reset.
module tb_mr_wb_arb;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
   logic [29:0] m0_addr, m1_addr;
   logic [3:0]  m0_sel, m1_sel;
   logic [31:0] m0_dat, m1_dat;
   logic        m0_ack, m0_err, m0_stall, m1_ack, m1_err, m1_stall;
   logic [31:0] m0_rdat, m1_rdat;
   logic        s_cyc, s_stb, s_we;
   logic [29:0] s_addr;
   logic [3:0]  s_sel;
   logic [31:0] s_dat_o, s_dat_i;
   logic        s_ack, s_err, s_stall;
   logic [1:0]  grant;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   mr_wb_arb #(.XLEN(32), .AW(30), .TIMEOUT(4)) dut (
      .clk(clk), .reset(reset),
      .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_addr_i(m0_addr),
      .m0_sel_i(m0_sel), .m0_dat_i(m0_dat), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
      .m0_stall_o(m0_stall), .m0_dat_o(m0_rdat),
      .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_addr_i(m1_addr),
      .m1_sel_i(m1_sel), .m1_dat_i(m1_dat), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
      .m1_stall_o(m1_stall), .m1_dat_o(m1_rdat),
      .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_addr_o(s_addr), .s_sel_o(s_sel),
      .s_dat_o(s_dat_o), .s_ack_i(s_ack), .s_err_i(s_err), .s_stall_i(s_stall),
      .s_dat_i(s_dat_i), .grant_o(grant)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs change here, checks follow a #1 settle.
   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_addr = 30'h0; m0_sel = 4'hf; m0_dat = 32'h0;
      m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_addr = 30'h0; m1_sel = 4'hf; m1_dat = 32'h0;
      s_ack = 0; s_err = 0; s_stall = 0; s_dat_i = 32'h0;
      nxt(); nxt();
      #1;
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_scyc", 32'(s_cyc), 32'h0);

      // Simultaneous request straight out of reset; stray ack/err in IDLE must be dropped.
      reset = 1'b0;
      m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_addr = 30'h55; m0_dat = 32'h1234_5678;
      m1_cyc = 1; m1_stb = 1; m1_addr = 30'h77;
      s_ack = 1; s_err = 1; s_dat_i = 32'hA5A5_0001;
      #1;
      chk("idle_grant", 32'(grant), 32'h0);
      chk("idle_scyc", 32'(s_cyc), 32'h0);
      chk("idle_m0_stall", 32'(m0_stall), 32'h1);
      chk("idle_m0_ack", 32'(m0_ack), 32'h0);
      chk("idle_m1_err", 32'(m1_err), 32'h0);
      chk("idle_m1_dat", m1_rdat, 32'hA5A5_0001);
      nxt();
      s_ack = 1; s_err = 0;
      #1;
      chk("tie_grant", 32'(grant), 32'h1);
      chk("tie_m1_stall", 32'(m1_stall), 32'h1);
      chk("tie_saddr", 32'(s_addr), 32'h55);
      chk("tie_sdat", s_dat_o, 32'h1234_5678);
      chk("tie_swe", 32'(s_we), 32'h1);
      chk("tie_m0_ack", 32'(m0_ack), 32'h1);
      chk("tie_m1_ack", 32'(m1_ack), 32'h0);
      nxt();
      m0_cyc = 0; m0_stb = 0; m0_we = 0; s_ack = 0;
      #1;
      chk("drop_scyc", 32'(s_cyc), 32'h0);
      nxt();
      s_ack = 1; s_err = 1;
      #1;
      chk("hand_grant", 32'(grant), 32'h2);
      chk("hand_saddr", 32'(s_addr), 32'h77);
      chk("both_m1_ack", 32'(m1_ack), 32'h1);
      chk("both_m1_err", 32'(m1_err), 32'h1);
      chk("both_m0_err", 32'(m0_err), 32'h0);
      nxt();
      m1_cyc = 0; m1_stb = 0; s_ack = 0; s_err = 0;
      nxt();
      #1;
      chk("back_idle", 32'(grant), 32'h0);

      // m1 read of 0x100 with two stall cycles.
      m1_cyc = 1; m1_stb = 1; m1_addr = 30'h100; s_stall = 1;
      nxt();
      #1;
      chk("rd_grant", 32'(grant), 32'h2);
      chk("rd_saddr", 32'(s_addr), 32'h100);
      chk("rd_stall0", 32'(m1_stall), 32'h1);
      nxt();
      #1;
      chk("rd_stall1", 32'(m1_stall), 32'h1);
      nxt();
      s_stall = 0; s_ack = 1; s_dat_i = 32'hDEAD_BEEF;
      #1;
      chk("rd_stall2", 32'(m1_stall), 32'h0);
      chk("rd_ack", 32'(m1_ack), 32'h1);
      chk("rd_dat", m1_rdat, 32'hDEAD_BEEF);
      chk("rd_m0_ack", 32'(m0_ack), 32'h0);
      nxt();
      m1_cyc = 0; m1_stb = 0; s_ack = 0;
      nxt();

      // Both hold cyc; each owner drops for one cycle after its ack.
      m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
      for (int i = 0; i < 4; i++) begin
         nxt();
         m0_cyc = 1; m1_cyc = 1; s_ack = 1;
         #1;
         chk($sformatf("rr_grant%0d", i), 32'(grant), (i % 2 == 0) ? 32'h1 : 32'h2);
         chk($sformatf("rr_ack%0d", i), 32'((i % 2 == 0) ? m0_ack : m1_ack), 32'h1);
         nxt();
         s_ack = 0;
         if (i % 2 == 0) m0_cyc = 0; else m1_cyc = 0;
         if (i == 3) begin m0_cyc = 0; m1_cyc = 0; end
      end
      m0_stb = 0; m1_stb = 0;
      nxt();

      // Watchdog: slave never answers, TIMEOUT=4.
      m0_cyc = 1; m0_stb = 1; m0_addr = 30'h200;
      for (int i = 0; i < 4; i++) begin
         nxt();
         #1;
         chk($sformatf("wd_wait_err%0d", i), 32'(m0_err), 32'h0);
         chk($sformatf("wd_wait_cyc%0d", i), 32'(s_cyc), 32'h1);
      end
      nxt();
      #1;
      chk("wd_err", 32'(m0_err), 32'h1);
      chk("wd_scyc", 32'(s_cyc), 32'h0);
      chk("wd_sstb", 32'(s_stb), 32'h0);
      nxt();
      m0_cyc = 0; m0_stb = 0;
      #1;
      chk("wd_idle", 32'(grant), 32'h0);
      chk("wd_err_done", 32'(m0_err), 32'h0);
      nxt();

      // Reset while m0 owns a stalled strobe; a late ack must not leak through.
      m0_cyc = 1; m0_stb = 1; s_stall = 1;
      nxt();
      #1;
      chk("rs_grant", 32'(grant), 32'h1);
      chk("rs_scyc", 32'(s_cyc), 32'h1);
      reset = 1;
      nxt();
      s_ack = 1;
      #1;
      chk("rs_after_scyc", 32'(s_cyc), 32'h0);
      chk("rs_after_grant", 32'(grant), 32'h0);
      chk("rs_late_ack", 32'(m0_ack), 32'h0);
      nxt();
      reset = 0; s_ack = 0; s_stall = 0;
      m0_cyc = 1; m1_cyc = 1;
      nxt();
      #1;
      chk("rs_tie_grant", 32'(grant), 32'h1);
      m0_cyc = 0; m1_cyc = 0; m0_stb = 0;
      nxt();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

endmodule
